// File: rtl/imem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// imem_ctrl_pkg
// Shared definitions for the instruction-memory boot loader: the loader state
// encoding, the default memory size and the number of bytes in a word.
// -----------------------------------------------------------------------------
package imem_ctrl_pkg;

   localparam int unsigned MEM_BYTES_DEFAULT = 1024;
   localparam int unsigned BYTES_PER_WORD    = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } loader_state_e;

endpackage

// File: rtl/imem_boot_loader_if.sv
// -----------------------------------------------------------------------------
// imem_boot_loader_if
// Bundles the two buses the boot loader sits between:
//   - byte stream from the host/debug source: in_valid, in_data, in_ready
//   - instruction memory byte write port:     mem_we, mem_addr, mem_wdata
// Modports:
//   master : the loader (consumes the stream, drives the memory write port)
//   slave  : the environment (byte source plus instruction memory)
// -----------------------------------------------------------------------------
interface imem_boot_loader_if #(
   parameter int unsigned ADDR_W = 10
) ();

   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;

   modport master (
      input  in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
// Fills the byte-addressed instruction memory from an external byte stream and
// holds the core in stall until the image is complete. Bytes arrive MSB of each
// word first and are written to ascending addresses, giving big-endian words.
//
// Ports:
//   CLK         single clock, rising edge
//   Reset       synchronous, active-high reset
//   start       one-cycle load request, honoured in IDLE and DONE only
//   len_words   number of 32-bit words to load, sampled with start
//   bus         imem_boot_loader_if.master: byte stream in, memory write out
//   core_stall  holds core PC and fetch while high
//   load_done   high while the loader sits in DONE
//   load_err    one-cycle pulse when a start is rejected (image too large)
// -----------------------------------------------------------------------------
module imem_boot_loader
   import imem_ctrl_pkg::*;
#(
   parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
   parameter int unsigned ADDR_W    = $clog2(MEM_BYTES)
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              start,
   input  logic [ADDR_W-2:0] len_words,
   imem_boot_loader_if.master bus,
   output logic              core_stall,
   output logic              load_done,
   output logic              load_err
);

   // Largest legal request in words; fits in ADDR_W bits for any power-of-two size.
   localparam logic [ADDR_W-1:0] MAX_WORDS = ADDR_W'(MEM_BYTES / BYTES_PER_WORD);

   loader_state_e     state_q,  state_d;
   logic [ADDR_W:0]   cnt_q,    cnt_d;
   logic [ADDR_W:0]   target_q, target_d;
   logic              we_q,     we_d;
   logic [ADDR_W-1:0] addr_q,   addr_d;
   logic [7:0]        wdata_q,  wdata_d;
   logic              stall_q,  stall_d;
   logic              done_q,   done_d;
   logic              err_q,    err_d;

   logic              xfer;
   logic              too_long;
   logic [ADDR_W:0]   len_bytes;

   // Four bytes per word: the byte target is len_words shifted left by two.
   assign len_bytes = {len_words, 2'b00};
   assign too_long  = {1'b0, len_words} > MAX_WORDS;

   // in_ready is decoded straight from state so a byte can move every cycle.
   assign bus.in_ready = (state_q == LOAD);
   assign xfer         = bus.in_valid && (state_q == LOAD);

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      target_d = target_q;
      we_d     = 1'b0;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      err_d    = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               if (too_long) begin
                  err_d = 1'b1;
               end else if (len_words == '0) begin
                  state_d = DONE;
               end else begin
                  target_d = len_bytes;
                  cnt_d    = '0;
                  state_d  = LOAD;
               end
            end
         end
         LOAD: begin
            if (xfer) begin
               we_d    = 1'b1;
               addr_d  = cnt_q[ADDR_W-1:0];
               wdata_d = bus.in_data;
               cnt_d   = cnt_q + 1'b1;
               if ((cnt_q + 1'b1) == target_q) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // The final byte's write is on the port this cycle.
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Stall drops only once DONE has been occupied for a full cycle and is
      // staying put; leaving DONE for LOAD raises it again on the same edge.
      stall_d = !((state_q == DONE) && (state_d == DONE));
      done_d  = (state_d == DONE);
   end

   always_ff @(posedge CLK) begin
      // NOTE: Reset is sampled on the clock edge (synchronous), so it lives inside
      // the edge-triggered block and overrides any start seen on the same edge.
      if (Reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         target_q <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         stall_q  <= 1'b1;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         target_q <= target_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         stall_q  <= stall_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign core_stall    = stall_q;
   assign load_done     = done_q;
   assign load_err      = err_q;

endmodule
